// File: rtl/ethpkg.sv
// ethpkg: shared Ethernet transmit/receive types and CRC-32 constants
package ethpkg;
  typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_t;
  localparam logic [31:0] CRC_POLY = 32'hedb88320;
  localparam logic [31:0] CRC_INIT = 32'hffffffff;
  localparam int ETH_MINLEN = 60;
  localparam int FCS_BYTES = 4;
endpackage

// File: rtl/ecrc_byte_step.sv
// ecrc_byte_step: combinational reflected CRC-32 update by one byte
module ecrc_byte_step
  import ethpkg::*;
#(
  parameter logic [31:0] POLY = ethpkg::CRC_POLY
) (
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] nxt
);
  always_comb begin
    nxt = crc ^ {24'h0, data};
    for (int k = 0; k < 8; k++) nxt = nxt[0] ? ((nxt >> 1) ^ POLY) : (nxt >> 1);
  end
endmodule

// File: rtl/addecrc_pad.sv
// addecrc_pad: optional min-length zero pad plus FCS append on a byte stream
// Define ADDECRC_PAD_EN to enable padding up to MINLEN bytes before the FCS.
module addecrc_pad
  import ethpkg::*;
#(
  parameter logic [31:0] CRC_POLY = ethpkg::CRC_POLY,
  parameter logic [31:0] CRC_INIT = ethpkg::CRC_INIT
`ifdef ADDECRC_PAD_EN
  , parameter int MINLEN = ETH_MINLEN
`endif
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_v,
  input  logic [7:0] i_byte,
  output logic       o_v,
  output logic [7:0] o_byte
);
  state_t state;
  logic [31:0] crc, crc_nxt, inv;
  logic [7:0] d, fcs_b;
  logic [1:0] idx;
  logic en_r, v_q, start;
`ifdef ADDECRC_PAD_EN
  logic [5:0] len, len_inc;
  assign len_inc = (len == 6'd63) ? len : len + 6'd1;
`endif
  // a new frame only starts on a genuine rising edge of i_v
  assign start = i_v && !v_q;
  assign d = (state == IDLE || (state == DATA && i_v)) ? i_byte : 8'h00;
  assign inv = ~crc;
  assign fcs_b = inv[{idx, 3'b000} +: 8];
  ecrc_byte_step #(.POLY(CRC_POLY)) u_step (
    .crc(state == IDLE ? CRC_INIT : crc),
    .data(d),
    .nxt(crc_nxt)
  );
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      o_v <= 1'b0;
      o_byte <= 8'h00;
      crc <= CRC_INIT;
      en_r <= 1'b0;
      idx <= 2'd0;
      v_q <= 1'b0;
`ifdef ADDECRC_PAD_EN
      len <= 6'd0;
`endif
    end else begin
      v_q <= i_v;
      case (state)
        IDLE: begin
          o_v <= start;
          o_byte <= start ? i_byte : 8'h00;
          if (start) begin
            state <= DATA;
            en_r <= i_en;
            crc <= crc_nxt;
`ifdef ADDECRC_PAD_EN
            len <= 6'd1;
`endif
          end
        end
        DATA:
          if (i_v) begin
            o_byte <= i_byte;
            crc <= crc_nxt;
`ifdef ADDECRC_PAD_EN
            len <= len_inc;
`endif
          end else if (!en_r) begin
            state <= IDLE;
            o_v <= 1'b0;
            o_byte <= 8'h00;
          end
`ifdef ADDECRC_PAD_EN
          else if (len < 6'(MINLEN)) begin
            o_byte <= 8'h00;
            crc <= crc_nxt;
            len <= len_inc;
            idx <= 2'd0;
            state <= (len_inc >= 6'(MINLEN)) ? FCS : PAD;
          end
`endif
          else begin
            o_byte <= fcs_b;
            idx <= 2'd1;
            state <= FCS;
          end
`ifdef ADDECRC_PAD_EN
        PAD: begin
          o_byte <= 8'h00;
          crc <= crc_nxt;
          len <= len_inc;
          state <= (len_inc >= 6'(MINLEN)) ? FCS : PAD;
        end
`endif
        default: begin
          o_byte <= fcs_b;
          idx <= idx + 2'd1;
          if (idx == 2'(FCS_BYTES - 1)) state <= IDLE;
        end
      endcase
    end
endmodule
